lc3b_mem_seq: RTL and testbench
===============================

LC3B_MEM_SEQ -- requirements
Module: lc3b_mem_seq

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, the address width.
REQ-002 SHALL have parameter DATA_W, default 16, the data width: a multiple of 8, at least 16.
REQ-003 SHALL have parameter TIMEOUT, default 15, the maximum number of wait cycles for mem_ready (range 1..255).
REQ-004 SHALL have one clock and an asynchronous, active-low reset.
REQ-005 Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  1  access request; sampled only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  1  1 = word, 0 = byte.
- req_sext  in  1  sign-extend a byte load (0 = zero-extend).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data; a byte store uses bits [7:0].
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done: misaligned access or timeout.
- rdata  out  DATA_W  load result; held until the next done.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_be  out  DATA_W/8  byte-lane enables.
- mem_addr  out  ADDR_W  registered address (MAR).
- mem_wdata  out  DATA_W  registered store data (MDR).
- mem_rdata  in  DATA_W  memory read data.
- mem_ready  in  1  memory completes the access in this cycle.

Function
REQ-006 SHALL implement the states IDLE, ADDR, ACCESS, DONE and ERR.
REQ-007 IDLE, with req=1: SHALL latch addr, we, size, sext and wdata, then go to ADDR (cycle 1).
REQ-008 ADDR: SHALL drive mem_addr from the latch and compute mem_be/mem_wdata.
- Word access with addr[0]=1: SHALL go to ERR; mem_en never asserts.
- Otherwise: SHALL go to ACCESS.
REQ-009 ACCESS: SHALL hold mem_en=1 and mem_we=latched we. The wait counter starts at 0 on entry and increments each cycle mem_ready=0.
REQ-010 ACCESS, with mem_ready=1: SHALL capture the load data, deassert mem_en next cycle, and go to DONE.
REQ-011 ACCESS: when the wait counter equals TIMEOUT with mem_ready=0, SHALL deassert mem_en and go to ERR.
REQ-012 DONE: SHALL pulse done=1, err=0 for one cycle, then go to IDLE.
- ERR: SHALL pulse done=1, err=1 for one cycle, then go to IDLE.
- Zero-wait latency: req at cycle 0, mem_en at cycle 2, done at cycle 3.
REQ-013 Word access: mem_be SHALL be all ones and mem_wdata=req_wdata.
REQ-014 Byte access: mem_be SHALL be one-hot at lane addr[0]. Byte store data SHALL be replicated on every lane.
REQ-015 Byte load: rdata SHALL be the selected lane, zero- or sign-extended to DATA_W per sext. A word load SHALL pass mem_rdata through unchanged.
REQ-016 Stores SHALL leave rdata unchanged. An errored load SHALL leave rdata unchanged.
REQ-017 req while busy=1 SHALL be ignored: no queueing. req asserted in the done cycle SHALL be ignored; the next req is accepted in IDLE.
REQ-018 mem_ready outside ACCESS SHALL be ignored.
REQ-019 The wait counter width SHALL be derived from TIMEOUT; wrap-around is impossible by construction.

Reset
REQ-020 rst_n=0 SHALL at once force IDLE and clear the wait counter.
- All outputs SHALL go to 0, including rdata, mem_addr, mem_wdata and mem_be.
REQ-021 Reset during ACCESS SHALL abort the access. mem_en SHALL drop asynchronously, and no done is issued.
REQ-022 After rst_n rises, the first req SHALL be accepted on the next rising edge.

Structure
REQ-023 A shared package lc3b_pkg SHALL hold:
- the state enumeration;
- the size encodings SIZE_BYTE/SIZE_WORD;
- the defaults for ADDR_W, DATA_W and TIMEOUT.
REQ-024 Byte-lane selection and extension SHALL be a sub-module lc3b_byte_ext (combinational: lane, sext -> DATA_W result).
REQ-025 All other logic SHALL live in one registered FSM with a registered-output process.

Verification
REQ-026 Word load, addr 0x3000, mem_ready=1 on the first ACCESS cycle, mem_rdata=0xBEEF -> done at cycle 3, err=0, rdata=0xBEEF, mem_be=2'b11.
REQ-027 Byte load, addr 0x3001, sext=1, mem_rdata=0x80FF -> mem_be=2'b10, rdata=0xFF80.
- Same with sext=0 -> rdata=0x0080.
REQ-028 Byte store, addr 0x2000, wdata=0x12A5 -> mem_we=1, mem_be=2'b01, mem_wdata=0xA5A5.
REQ-029 Word store, addr 0x2001 -> mem_en stays 0; done=1 and err=1 at cycle 2.
REQ-030 TIMEOUT=3, mem_ready held 0 -> mem_en high for exactly 4 cycles, then done=1, err=1, rdata unchanged.
REQ-031 rst_n pulsed low on the second ACCESS cycle -> all outputs 0 at once, no done.
- A new req after reset completes normally.

Source files
------------

// File: rtl/lc3b_pkg.sv
// Shared types and default sizing for the LC-3b memory access sequencer.
package lc3b_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR   = 3'd1,
    S_ACCESS = 3'd2,
    S_DONE   = 3'd3,
    S_ERR    = 3'd4
  } state_e;

  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_WORD = 1'b1;

  localparam int ADDR_W_DEF  = 16;
  localparam int DATA_W_DEF  = 16;
  localparam int TIMEOUT_DEF = 15;

endpackage

// File: rtl/lc3b_byte_ext.sv
// Picks one byte lane out of a memory word and zero- or sign-extends it.
module lc3b_byte_ext #(
  parameter int DATA_W = 16,
  parameter int LANE_W = 1
) (
  input  logic [DATA_W-1:0] data,
  input  logic [LANE_W-1:0] lane,
  input  logic              sext,
  output logic [DATA_W-1:0] result
);

  localparam int NB = DATA_W / 8;

  logic signed [7:0] byte_sel;

  always_comb begin
    byte_sel = '0;
    for (int i = 0; i < NB; i++) begin
      if (lane == LANE_W'(i)) byte_sel = data[8*i +: 8];
    end
    result = {{(DATA_W-8){sext & byte_sel[7]}}, byte_sel};
  end

endmodule

// File: rtl/lc3b_mem_seq.sv
// LC-3b memory access sequencer: MAR/MDR staging, byte-lane steering,
// bounded wait on mem_ready and a one-cycle done/err completion pulse.
module lc3b_mem_seq
  import lc3b_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req,
  input  logic                req_we,
  input  logic                req_size,
  input  logic                req_sext,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [DATA_W-1:0]   rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready
);

  localparam int NB     = DATA_W / 8;
  localparam int LANE_W = $clog2(NB);
  localparam int CNT_W  = $clog2(TIMEOUT + 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic                size_q, size_d;
  logic                sext_q, sext_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [NB-1:0]       mem_be_q, mem_be_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

  logic [LANE_W-1:0]   lane;
  logic [DATA_W-1:0]   ext_res;
  logic [DATA_W-1:0]   load_val;

  assign lane = addr_q[LANE_W-1:0];

  lc3b_byte_ext #(
    .DATA_W (DATA_W),
    .LANE_W (LANE_W)
  ) u_byte_ext (
    .data   (mem_rdata),
    .lane   (lane),
    .sext   (sext_q),
    .result (ext_res)
  );

  assign load_val = (size_q == SIZE_WORD) ? mem_rdata : ext_res;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    we_d        = we_q;
    size_d      = size_q;
    sext_d      = sext_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          addr_d  = req_addr;
          we_d    = req_we;
          size_d  = req_size;
          sext_d  = req_sext;
          wdata_d = req_wdata;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        mem_addr_d = addr_q;
        cnt_d      = '0;
        if (size_q == SIZE_BYTE) begin
          mem_be_d    = {{(NB-1){1'b0}}, 1'b1} << lane;
          mem_wdata_d = {NB{wdata_q[7:0]}};
        end else begin
          mem_be_d    = '1;
          mem_wdata_d = wdata_q;
        end
        // A misaligned word never reaches the memory bus.
        if (size_q == SIZE_WORD && addr_q[0]) state_d = S_ERR;
        else                                  state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (mem_ready) begin
          if (!we_q) rdata_d = load_val;
          state_d = S_DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE) || (state_d == S_ERR);
    err_d    = (state_d == S_ERR);
    mem_en_d = (state_d == S_ACCESS);
    mem_we_d = (state_d == S_ACCESS) && we_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      size_q      <= 1'b0;
      sext_q      <= 1'b0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      size_q      <= size_d;
      sext_q      <= sext_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lc3b_mem_seq.sv
// Directed bench for lc3b_mem_seq with TIMEOUT=3 and hand-computed expectations.
module tb_lc3b_mem_seq;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic        req_we;
  logic        req_size;
  logic        req_sext;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] rdata;
  logic        mem_en;
  logic        mem_we;
  logic [1:0]  mem_be;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ready;

  int n_tests = 0;
  int n_fail  = 0;

  lc3b_mem_seq #(
    .ADDR_W  (16),
    .DATA_W  (16),
    .TIMEOUT (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_we    (req_we),
    .req_size  (req_size),
    .req_sext  (req_sext),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issues one request in cycle 0 and follows it until done (bounded).
  // mem_ready rises on the (ready_after)th ACCESS cycle, counting from 0.
  task automatic run_req(input logic we, input logic size, input logic sext,
                         input logic [15:0] addr, input logic [15:0] wdata,
                         input int ready_after, input logic [15:0] rd,
                         output int done_cyc, output int en_cnt, output logic err_o,
                         output logic [1:0] be_o, output logic [15:0] wd_o,
                         output logic we_o, output logic [15:0] addr_o);
    int n_en;
    n_en = 0; done_cyc = -1; err_o = 1'b0;
    be_o = '0; wd_o = '0; we_o = 1'b0; addr_o = '0;
    @(negedge clk);
    req = 1'b1; req_we = we; req_size = size; req_sext = sext;
    req_addr = addr; req_wdata = wdata; mem_rdata = rd; mem_ready = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      req = 1'b0;
      if (mem_en) begin
        if (n_en == 0) begin
          be_o = mem_be; wd_o = mem_wdata; we_o = mem_we; addr_o = mem_addr;
        end
        mem_ready = (n_en >= ready_after);
        n_en++;
      end else begin
        mem_ready = 1'b0;
      end
      if (done) begin
        done_cyc = c;
        err_o    = err;
        break;
      end
    end
    mem_ready = 1'b0;
    en_cnt = n_en;
    check("done_seen", 32'(done_cyc >= 0), 32'd1);
  endtask

  int          dc, ec;
  logic        e, w;
  logic [1:0]  be;
  logic [15:0] wd, ad;

  initial begin
    rst_n = 1'b1; req = 1'b0; req_we = 1'b0; req_size = 1'b0; req_sext = 1'b0;
    req_addr = '0; req_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done_err", 32'({done, err}), 32'd0);
    check("rst_bus", 32'({mem_en, mem_we, mem_be}), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_addr_wdata", {mem_addr, mem_wdata}, 32'd0);
    rst_n = 1'b1;

    // Word load, zero wait
    run_req(1'b0, 1'b1, 1'b0, 16'h3000, 16'h0000, 0, 16'hBEEF, dc, ec, e, be, wd, w, ad);
    check("wl_done_cyc", 32'(dc), 32'd3);
    check("wl_err", 32'(e), 32'd0);
    check("wl_rdata", 32'(rdata), 32'hBEEF);
    check("wl_be", 32'(be), 32'h3);
    check("wl_addr", 32'(ad), 32'h3000);
    check("wl_en_cnt", 32'(ec), 32'd1);
    check("wl_we", 32'(w), 32'd0);

    // req held in the done cycle must be ignored
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    check("done_req_ignored_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("done_req_ignored_busy2", 32'(busy), 32'd0);

    // Byte load, high lane, sign-extend
    run_req(1'b0, 1'b0, 1'b1, 16'h3001, 16'h0000, 0, 16'h80FF, dc, ec, e, be, wd, w, ad);
    check("bls_be", 32'(be), 32'h2);
    check("bls_rdata", 32'(rdata), 32'hFF80);
    check("bls_err", 32'(e), 32'd0);

    // Byte load, high lane, zero-extend
    run_req(1'b0, 1'b0, 1'b0, 16'h3001, 16'h0000, 0, 16'h80FF, dc, ec, e, be, wd, w, ad);
    check("blz_rdata", 32'(rdata), 32'h0080);

    // Byte load, low lane, sign-extend
    run_req(1'b0, 1'b0, 1'b1, 16'h3000, 16'h0000, 0, 16'h7F85, dc, ec, e, be, wd, w, ad);
    check("bl0_be", 32'(be), 32'h1);
    check("bl0_rdata", 32'(rdata), 32'hFF85);

    // Byte store: lane 0, data replicated, rdata untouched
    run_req(1'b1, 1'b0, 1'b0, 16'h2000, 16'h12A5, 0, 16'h5555, dc, ec, e, be, wd, w, ad);
    check("bs_we", 32'(w), 32'd1);
    check("bs_be", 32'(be), 32'h1);
    check("bs_wdata", 32'(wd), 32'hA5A5);
    check("bs_rdata_kept", 32'(rdata), 32'hFF85);
    check("bs_err", 32'(e), 32'd0);

    // Misaligned word store
    run_req(1'b1, 1'b1, 1'b0, 16'h2001, 16'hCAFE, 0, 16'h0000, dc, ec, e, be, wd, w, ad);
    check("mis_en_cnt", 32'(ec), 32'd0);
    check("mis_done_cyc", 32'(dc), 32'd2);
    check("mis_err", 32'(e), 32'd1);

    // Word load with two wait cycles
    run_req(1'b0, 1'b1, 1'b0, 16'h4002, 16'h0000, 2, 16'h1234, dc, ec, e, be, wd, w, ad);
    check("ws_done_cyc", 32'(dc), 32'd5);
    check("ws_en_cnt", 32'(ec), 32'd3);
    check("ws_rdata", 32'(rdata), 32'h1234);

    // Timeout: mem_ready never rises
    run_req(1'b0, 1'b1, 1'b0, 16'h4004, 16'h0000, 1000, 16'hDEAD, dc, ec, e, be, wd, w, ad);
    check("to_en_cnt", 32'(ec), 32'd4);
    check("to_done_cyc", 32'(dc), 32'd6);
    check("to_err", 32'(e), 32'd1);
    check("to_rdata_kept", 32'(rdata), 32'h1234);

    // Reset on the second ACCESS cycle
    @(negedge clk);
    req = 1'b1; req_we = 1'b0; req_size = 1'b1; req_sext = 1'b0;
    req_addr = 16'h5000; mem_rdata = 16'h7777; mem_ready = 1'b0;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    check("ra_en_first", 32'(mem_en), 32'd1);
    @(negedge clk);
    check("ra_en_second", 32'(mem_en), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("ra_en_async", 32'({mem_en, mem_we, mem_be}), 32'd0);
    check("ra_busy_async", 32'({busy, done, err}), 32'd0);
    check("ra_rdata_async", 32'(rdata), 32'd0);
    check("ra_addr_async", {mem_addr, mem_wdata}, 32'd0);
    @(negedge clk);
    check("ra_no_done", 32'(done), 32'd0);
    rst_n = 1'b1;

    run_req(1'b0, 1'b1, 1'b0, 16'h3000, 16'h0000, 0, 16'hBEEF, dc, ec, e, be, wd, w, ad);
    check("post_rst_done_cyc", 32'(dc), 32'd3);
    check("post_rst_rdata", 32'(rdata), 32'hBEEF);
    check("post_rst_err", 32'(e), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
